sa_channel_feeder: RTL and testbench

Synthetic-aperture beamforming sequencer that drives the per-point channel summer (`summ_sa`). For each output point it reads one delayed sample per channel from the channel sample memory at address `base_idx + delay[ch]`. It then frames the samples for the summer as `start_sum`, then `NUM_CHANNELS` beats of `sum_en`/`delayed_sample`, then `done_channel`. It sits between the per-channel sample memories and `summ_sa`, and iterates over a contiguous run of output points per `start`.

---
 rtl/sa_bf_pkg.sv | 20 ++
 rtl/sa_channel_feeder_if.sv | 49 ++++
 rtl/sa_delay_table.sv | 29 ++
 rtl/sa_channel_feeder.sv | 153 +++++++++++++++
 tb/tb_sa_channel_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_bf_pkg.sv
// Shared types and helpers for the synthetic-aperture channel feeder.
// FSM state encoding, channel-index width helper and the out-of-range sample value.
package sa_bf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ISSUE,
    S_DRAIN,
    S_CLOSE
  } fsm_state_t;

  // Channel index width; at least one bit so a 1-channel build still elaborates.
  function automatic int CH_W(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  localparam logic [63:0] OOR_SAMPLE = '0;

endpackage

// File: rtl/sa_channel_feeder_if.sv
// Bus bundle for sa_channel_feeder: run control, delay-table writes, sample memory and summer.
// Optional ch_mask input is present when SA_FEED_CH_MASK_EN is defined.
interface sa_channel_feeder_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int DELAY_WIDTH  = 10
) ();
  localparam int CW = sa_bf_pkg::CH_W(NUM_CHANNELS);

  logic                    start;
  logic [ADDR_WIDTH-1:0]   start_idx;
  logic [ADDR_WIDTH-1:0]   num_points;
  logic                    delay_we;
  logic [CW-1:0]           delay_ch;
  logic [DELAY_WIDTH-1:0]  delay_val;
  logic                    mem_rd_en;
  logic [CW-1:0]           mem_ch;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic                    start_sum;
  logic                    sum_en;
  logic [DATA_WIDTH-1:0]   delayed_sample;
  logic                    done_channel;
  logic                    busy;
  logic                    done;
`ifdef SA_FEED_CH_MASK_EN
  logic [NUM_CHANNELS-1:0] ch_mask;
`endif

  modport slave (
`ifdef SA_FEED_CH_MASK_EN
    input  ch_mask,
`endif
    input  start, start_idx, num_points, delay_we, delay_ch, delay_val, mem_rd_data,
    output mem_rd_en, mem_ch, mem_addr, start_sum, sum_en, delayed_sample,
    output done_channel, busy, done
  );

  modport master (
`ifdef SA_FEED_CH_MASK_EN
    output ch_mask,
`endif
    output start, start_idx, num_points, delay_we, delay_ch, delay_val, mem_rd_data,
    input  mem_rd_en, mem_ch, mem_addr, start_sum, sum_en, delayed_sample,
    input  done_channel, busy, done
  );

endinterface

// File: rtl/sa_delay_table.sv
// Per-channel delay register file: one write port, combinational read by channel index.
module sa_delay_table import sa_bf_pkg::*; #(
  parameter int NUM_CHANNELS = 4,
  parameter int DELAY_WIDTH  = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_we,
  input  logic [CH_W(NUM_CHANNELS)-1:0]     i_wr_ch,
  input  logic [DELAY_WIDTH-1:0]            i_wr_val,
  input  logic [CH_W(NUM_CHANNELS)-1:0]     i_rd_ch,
  output logic [DELAY_WIDTH-1:0]            o_rd_val
);
  logic [DELAY_WIDTH-1:0] r_tab [NUM_CHANNELS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) r_tab[i] <= '0;
    end else if (i_we && (int'(i_wr_ch) < NUM_CHANNELS)) begin
      r_tab[i_wr_ch] <= i_wr_val;
    end
  end

  always_comb begin
    o_rd_val = '0;
    if (int'(i_rd_ch) < NUM_CHANNELS) o_rd_val = r_tab[i_rd_ch];
  end

endmodule

// File: rtl/sa_channel_feeder.sv
// Sequencer feeding summ_sa: per point reads base+delay[ch] for every channel and frames the beats.
// Build option SA_FEED_CH_MASK_EN adds a per-run channel mask that forces zero beats.
module sa_channel_feeder import sa_bf_pkg::*; #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int DELAY_WIDTH  = 10
) (
  input logic               clk,
  input logic               reset,
  sa_channel_feeder_if.slave bus
);
  localparam int CW  = CH_W(NUM_CHANNELS);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         LAST_CH = CW'(NUM_CHANNELS - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO_SAMPLE = OOR_SAMPLE[DATA_WIDTH-1:0];

  fsm_state_t              r_state;
  logic [AW1-1:0]          r_base;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_start_sum;
  logic                    r_done_channel;
  logic                    r_mem_rd_en;
  logic [CW-1:0]           r_mem_ch;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic                    r_ret_valid;
  logic                    r_ret_zero;
`ifdef SA_FEED_CH_MASK_EN
  logic [NUM_CHANNELS-1:0] r_mask;
`endif

  logic [CW-1:0]           w_next_ch;
  logic [DELAY_WIDTH-1:0]  w_delay;
  logic [AW1-1:0]          w_sum;
  logic                    w_in_range;
  logic                    w_issue_en;

  sa_delay_table #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DELAY_WIDTH  (DELAY_WIDTH)
  ) u_delay_table (
    .clk      (clk),
    .reset    (reset),
    .i_we     (bus.delay_we && !r_busy),
    .i_wr_ch  (bus.delay_ch),
    .i_wr_val (bus.delay_val),
    .i_rd_ch  (w_next_ch),
    .o_rd_val (w_delay)
  );

  // Address for the channel about to be issued; base past the memory end is never in range,
  // which also keeps the ADDR_WIDTH+1 bit sum from aliasing back into range.
  always_comb begin
    w_next_ch  = (r_state == S_ISSUE) ? r_mem_ch + CW'(1) : '0;
    w_sum      = r_base + AW1'(w_delay);
    w_in_range = !r_base[ADDR_WIDTH] && !w_sum[ADDR_WIDTH];
`ifdef SA_FEED_CH_MASK_EN
    w_issue_en = w_in_range && !r_mask[w_next_ch];
`else
    w_issue_en = w_in_range;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_start_sum    <= 1'b0;
      r_done_channel <= 1'b0;
      r_mem_rd_en    <= 1'b0;
      r_mem_ch       <= '0;
      r_mem_addr     <= '0;
      r_ret_valid    <= 1'b0;
      r_ret_zero     <= 1'b0;
`ifdef SA_FEED_CH_MASK_EN
      r_mask         <= '0;
`endif
    end else begin
      r_done         <= 1'b0;
      r_start_sum    <= 1'b0;
      r_done_channel <= 1'b0;
      r_mem_rd_en    <= 1'b0;
      r_ret_valid    <= 1'b0;
      r_ret_zero     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_points != '0) begin
              r_base      <= AW1'(bus.start_idx);
              r_cnt       <= bus.num_points;
              r_busy      <= 1'b1;
              r_start_sum <= 1'b1;
              r_state     <= S_START;
`ifdef SA_FEED_CH_MASK_EN
              r_mask      <= bus.ch_mask;
`endif
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_START, S_ISSUE: begin
          // The beat returned next cycle mirrors whether this cycle actually read memory.
          if (r_state == S_ISSUE) begin
            r_ret_valid <= 1'b1;
            r_ret_zero  <= !r_mem_rd_en;
          end
          if ((r_state == S_ISSUE) && (r_mem_ch == LAST_CH)) begin
            r_state <= S_DRAIN;
          end else begin
            r_state     <= S_ISSUE;
            r_mem_ch    <= w_next_ch;
            r_mem_rd_en <= w_issue_en;
            r_mem_addr  <= w_issue_en ? w_sum[ADDR_WIDTH-1:0] : '0;
          end
        end
        S_DRAIN: begin
          r_done_channel <= 1'b1;
          r_done         <= (r_cnt == ADDR_WIDTH'(1));
          r_state        <= S_CLOSE;
        end
        S_CLOSE: begin
          r_base <= r_base + AW1'(1);
          r_cnt  <= r_cnt - ADDR_WIDTH'(1);
          if (r_cnt == ADDR_WIDTH'(1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_start_sum <= 1'b1;
            r_state     <= S_START;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en      = r_mem_rd_en;
  assign bus.mem_ch         = r_mem_ch;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.start_sum      = r_start_sum;
  assign bus.sum_en         = r_ret_valid;
  assign bus.delayed_sample = (r_ret_valid && !r_ret_zero) ? bus.mem_rd_data : ZERO_SAMPLE;
  assign bus.done_channel   = r_done_channel;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;

endmodule

// File: tb/tb_sa_channel_feeder.sv
// Scoreboard bench for sa_channel_feeder: a point/channel model fills expectation queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sa_channel_feeder;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int DLW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_channel_feeder_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DELAY_WIDTH(DLW)) bus ();

  sa_channel_feeder #(.DATA_WIDTH(DW), .NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DELAY_WIDTH(DLW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [DW-1:0]  beat_q [$];
  bit             close_q [$];
  int unsigned    rd_q [$];
  int unsigned    done0_pending = 0;
  int unsigned    delay_m [N];
  logic [N-1:0]   mask_m = '0;

  int unsigned ss_cyc = 0, close_cyc = 0, beat_idx = 0, beats_seen = 0;
  bit          cont_pending = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input int unsigned c, input int unsigned a);
    return DW'(c * 1000 + a);
  endfunction

  // Synchronous sample memory; junk when not read so dropped beats must be forced to zero.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(int'(bus.mem_ch), int'(bus.mem_addr));
    else               bus.mem_rd_data <= DW'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: every DUT-presented event is matched against the model's queues.
  initial begin : monitor
    logic [DW-1:0] e;
    bit last;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.start_sum) begin
        chk("excl_start_sum_sum_en", bus.sum_en, 0);
        if (cont_pending) chk("frame_gap", cyc - close_cyc, 1);
        cont_pending = 0;
        ss_cyc = cyc;
        beat_idx = 0;
      end
      if (bus.sum_en) begin
        if (beat_q.size() == 0) fail("beat_unexpected");
        else begin
          e = beat_q.pop_front();
          chk("beat_value", bus.delayed_sample, e);
        end
        chk("beat_slot", cyc - ss_cyc, beat_idx + 2);
        beat_idx++;
        beats_seen++;
      end
      if (bus.done_channel) begin
        chk("excl_done_channel_sum_en", bus.sum_en, 0);
        chk("frame_beats", beat_idx, N);
        chk("close_slot", cyc - ss_cyc, N + 2);
        if (close_q.size() == 0) fail("close_unexpected");
        else begin
          last = close_q.pop_front();
          chk("done_with_last_close", bus.done, last);
          cont_pending = !last;
        end
        close_cyc = cyc;
      end else if (bus.done) begin
        if (done0_pending == 0) fail("done_unexpected");
        else done0_pending--;
      end
      if (bus.mem_rd_en) begin
        if (rd_q.size() == 0) fail("read_unexpected");
        else chk("read_ch_addr", int'(bus.mem_ch) * 4096 + int'(bus.mem_addr), rd_q.pop_front());
      end
    end
  end

  task automatic model_run(input int unsigned sidx, input int unsigned np);
    if (np == 0) done0_pending++;
    for (int unsigned p = 0; p < np; p++) begin
      for (int unsigned c = 0; c < N; c++) begin
        int unsigned a;
        a = sidx + p + delay_m[c];
        if (a < (1 << AW) && !mask_m[c]) begin
          rd_q.push_back(c * 4096 + a);
          beat_q.push_back(mem_word(c, a));
        end else begin
          beat_q.push_back('0);
        end
      end
      close_q.push_back(p == np - 1);
    end
  endtask

  task automatic wr_delay(input int unsigned ch, input int unsigned val);
    @(posedge clk); #1;
    bus.delay_we = 1'b1; bus.delay_ch = 2'(ch); bus.delay_val = DLW'(val);
    @(posedge clk); #1;
    bus.delay_we = 1'b0;
    delay_m[ch] = val;
  endtask

  task automatic wait_idle(input int unsigned budget);
    bit ok = 0;
    for (int unsigned k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!bus.busy && beat_q.size() == 0 && close_q.size() == 0 && rd_q.size() == 0
          && done0_pending == 0) begin
        ok = 1;
        break;
      end
    end
    chk("run_complete", ok, 1);
  endtask

  task automatic kick(input int unsigned sidx, input int unsigned np);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_idx = AW'(sidx); bus.num_points = AW'(np);
`ifdef SA_FEED_CH_MASK_EN
    bus.ch_mask = mask_m;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_sum_latency", bus.start_sum, np != 0);
    if (np == 0) chk("done_zero_run", bus.done, 1);
    else         chk("busy_in_run", bus.busy, 1);
  endtask

  task automatic run(input int unsigned sidx, input int unsigned np, input bit interfere);
    model_run(sidx, np);
    kick(sidx, np);
    if (interfere) begin
      repeat (3) begin @(posedge clk); #1; end
      bus.delay_we = 1'b1; bus.delay_ch = 2'd0; bus.delay_val = DLW'(7);
      bus.start = 1'b1; bus.start_idx = AW'(100); bus.num_points = AW'(5);
      @(posedge clk); #1;
      bus.delay_we = 1'b0; bus.start = 1'b0;
    end
    wait_idle((np + 2) * (N + 3) + 10);
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n0;
    bit hit;
    bus.start = 0; bus.start_idx = '0; bus.num_points = '0;
    bus.delay_we = 0; bus.delay_ch = '0; bus.delay_val = '0;
`ifdef SA_FEED_CH_MASK_EN
    bus.ch_mask = '0;
`endif
    for (int unsigned c = 0; c < N; c++) delay_m[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_sum", bus.start_sum, 0);
    chk("rst_sum_en", bus.sum_en, 0);
    chk("rst_done_channel", bus.done_channel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_delayed_sample", bus.delayed_sample, 0);
    rst = 0;

    for (int unsigned c = 0; c < N; c++) wr_delay(c, c);
    run(5, 1, 0);

    for (int unsigned c = 0; c < N; c++) wr_delay(c, 0);
    run(0, 3, 0);

    wr_delay(3, 3);
    run(1022, 1, 0);
    wr_delay(3, 0);

    run(10, 2, 1);
    wr_delay(0, 7);
    run(10, 1, 0);

    run(20, 0, 0);

    // Abort a run at its second beat; the frame remainder must never appear.
    model_run(0, 2);
    kick(0, 2);
    n0 = beats_seen;
    hit = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (beats_seen - n0 >= 2) begin hit = 1; break; end
    end
    chk("reached_second_beat", hit, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_start_sum", bus.start_sum, 0);
    chk("mid_rst_sum_en", bus.sum_en, 0);
    chk("mid_rst_delayed_sample", bus.delayed_sample, 0);
    chk("mid_rst_done_channel", bus.done_channel, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mem_rd_en", bus.mem_rd_en, 0);
    rst = 0;
    beat_q.delete(); close_q.delete(); rd_q.delete();
    cont_pending = 0;
    for (int unsigned c = 0; c < N; c++) delay_m[c] = 0;
    run(3, 1, 0);

    for (int unsigned it = 0; it < 30; it++) begin
      int unsigned sidx, np;
      for (int unsigned c = 0; c < N; c++)
        if ($urandom_range(0, 1) == 1) wr_delay(c, $urandom_range(0, (1 << DLW) - 1));
`ifdef SA_FEED_CH_MASK_EN
      mask_m = N'($urandom);
`endif
      sidx = ($urandom_range(0, 2) == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, 1023);
      np   = $urandom_range(0, 5);
      run(sidx, np, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
